// File: rtl/mat_vec_res_ser_pkg.sv
// Shared parameter package for the matrix-vector multiplier and its result
// serializer: parameter-set size tables, FSM encoding and sizing helpers.
package mat_vec_res_ser_pkg;

  typedef logic [63:0] param_set_t;

  localparam param_set_t SET_L1    = 64'("L1");
  localparam param_set_t SET_L3    = 64'("L3");
  localparam param_set_t SET_L5    = 64'("L5");
  localparam param_set_t SET_OTHER = 64'("other");

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Valid result bytes per matrix row for each parameter set.
  function automatic int unsigned row_size_bytes(input param_set_t set);
    case (set)
      SET_L1:  return 104;
      SET_L3:  return 159;
      SET_L5:  return 202;
      default: return 8;
    endcase
  endfunction

  // Never returns 0, so a counter or address for a single-entry range
  // still gets a legal one-bit width.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mat_vec_res_ser_if.sv
// Result-memory read port and byte-stream handshake between the serializer
// (master) and the multiplier memory / downstream consumer (slave).
interface mat_vec_res_ser_if
  import mat_vec_res_ser_pkg::*;
#(
  parameter int unsigned ADDR_W    = clog2(ceil_div(row_size_bytes(SET_L3) * 8, 64)),
  parameter int unsigned PROC_SIZE = 64
) ();

  logic                 o_res_en;
  logic [ADDR_W-1:0]    o_res_addr;
  logic [PROC_SIZE-1:0] i_res;
  logic [7:0]           o_byte;
  logic                 o_byte_valid;
  logic                 i_byte_ready;

  modport master (
    output o_res_en, o_res_addr, o_byte, o_byte_valid,
    input  i_res, i_byte_ready
  );

  modport slave (
    input  o_res_en, o_res_addr, o_byte, o_byte_valid,
    output i_res, i_byte_ready
  );

endinterface

// File: rtl/mat_vec_res_ser.sv
// Unloads the multiplier result memory word by word and streams the valid
// result bytes (lane 0 / MSB byte first) over a valid/ready byte interface.
module mat_vec_res_ser
  import mat_vec_res_ser_pkg::*;
#(
  parameter param_set_t  PARAMETER_SET      = SET_L3,
  parameter int unsigned N_GF               = 8,
  parameter int unsigned MAT_ROW_SIZE_BYTES = row_size_bytes(PARAMETER_SET),
  parameter int unsigned PROC_SIZE          = N_GF * 8,
  parameter int unsigned N_WORDS            = ceil_div(MAT_ROW_SIZE_BYTES * 8, PROC_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  mat_vec_res_ser_if.master res_if,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned ADDR_W = clog2(N_WORDS);
  localparam int unsigned LANE_W = clog2(N_GF);
  localparam int unsigned CNT_W  = clog2(MAT_ROW_SIZE_BYTES + 1);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_GF - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(MAT_ROW_SIZE_BYTES - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [PROC_SIZE-1:0] shreg_q;
  logic [LANE_W-1:0]    lane_q;
  logic [CNT_W-1:0]     byte_cnt_q;

  logic xfer;
  logic word_end;
  logic last_byte;

  assign xfer      = (state_q == S_SHIFT) && res_if.i_byte_ready;
  assign word_end  = (lane_q == LAST_LANE);
  assign last_byte = (byte_cnt_q == LAST_BYTE);

  // The read mux stays owned through S_DONE; busy already drops with o_done.
  assign res_if.o_res_en     = (state_q != S_IDLE);
  assign res_if.o_res_addr   = addr_q;
  assign res_if.o_byte       = shreg_q[PROC_SIZE-1 -: 8];
  assign res_if.o_byte_valid = (state_q == S_SHIFT);
  assign o_busy              = (state_q == S_RD) || (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign o_done              = (state_q == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: state_d gets a default first, so no branch can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_RD;
      S_RD:    state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (xfer) begin
          if (last_byte)     state_d = S_DONE;
          else if (word_end) state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte shift register plus word/lane/byte counters. Padding lanes of the
  // last word are never shown because last_byte wins over word_end.
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: shreg_q drives o_byte directly, so it is reset along with the counters.
    if (!i_rst) begin
      addr_q     <= '0;
      shreg_q    <= '0;
      lane_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q     <= '0;
            lane_q     <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          shreg_q <= res_if.i_res;
          lane_q  <= '0;
        end
        S_SHIFT: begin
          if (xfer) begin
            shreg_q    <= shreg_q << 8;
            lane_q     <= lane_q + 1'b1;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (word_end && !last_byte) addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_res_ser.sv
// Self-checking bench: three serializer instances (L1, L3, other) fed by
// byte-index memory models, a byte scoreboard and a table of unload runs.
module tb_mat_vec_res_ser;
  import mat_vec_res_ser_pkg::*;

  localparam int unsigned AW_L1 = clog2(ceil_div(row_size_bytes(SET_L1) * 8, 64));
  localparam int unsigned AW_L3 = clog2(ceil_div(row_size_bytes(SET_L3) * 8, 64));
  localparam int unsigned AW_OT = clog2(ceil_div(row_size_bytes(SET_OTHER) * 8, 64));

  typedef enum int {RDY_ALWAYS, RDY_RANDOM, RDY_HOLD5} rdy_mode_e;

  typedef struct {
    int        dut;
    rdy_mode_e mode;
    bit        poke;
    int        exp_bytes;
    int        exp_cycles;
    int        exp_max_addr;
    string     name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] ready_v;

  logic       valid_a  [3];
  logic [7:0] byte_a   [3];
  logic       res_en_a [3];
  int         addr_a   [3];
  logic       busy_a   [3];
  logic       done_a   [3];

  int         checks;
  int         errors;
  logic [7:0] exp_q [3][$];
  int         xfer_cnt [3];
  int         done_cnt [3];
  logic       hold_pend [3];
  logic [7:0] held_b [3];
  vec_t       vecs [5];

  mat_vec_res_ser_if #(.ADDR_W(AW_L1), .PROC_SIZE(64)) if_l1 ();
  mat_vec_res_ser_if #(.ADDR_W(AW_L3), .PROC_SIZE(64)) if_l3 ();
  mat_vec_res_ser_if #(.ADDR_W(AW_OT), .PROC_SIZE(64)) if_ot ();

  mat_vec_res_ser #(.PARAMETER_SET(SET_L1), .N_GF(8)) dut_l1 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start_v[0]), .res_if(if_l1.master),
    .o_busy(busy_a[0]), .o_done(done_a[0]));
  mat_vec_res_ser #(.PARAMETER_SET(SET_L3), .N_GF(8)) dut_l3 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start_v[1]), .res_if(if_l3.master),
    .o_busy(busy_a[1]), .o_done(done_a[1]));
  mat_vec_res_ser #(.PARAMETER_SET(SET_OTHER), .N_GF(8)) dut_ot (
    .i_clk(clk), .i_rst(rst_n), .i_start(start_v[2]), .res_if(if_ot.master),
    .o_busy(busy_a[2]), .o_done(done_a[2]));

  assign if_l1.i_byte_ready = ready_v[0];
  assign if_l3.i_byte_ready = ready_v[1];
  assign if_ot.i_byte_ready = ready_v[2];

  assign valid_a[0]  = if_l1.o_byte_valid;
  assign valid_a[1]  = if_l3.o_byte_valid;
  assign valid_a[2]  = if_ot.o_byte_valid;
  assign byte_a[0]   = if_l1.o_byte;
  assign byte_a[1]   = if_l3.o_byte;
  assign byte_a[2]   = if_ot.o_byte;
  assign res_en_a[0] = if_l1.o_res_en;
  assign res_en_a[1] = if_l3.o_res_en;
  assign res_en_a[2] = if_ot.o_res_en;
  assign addr_a[0]   = int'(if_l1.o_res_addr);
  assign addr_a[1]   = int'(if_l3.o_res_addr);
  assign addr_a[2]   = int'(if_ot.o_res_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory: word w holds byte indices 8w..8w+7, lane 0 in the MSB byte.
  function automatic logic [63:0] mem_word(input int w);
    logic [63:0] word;
    for (int j = 0; j < 8; j++) word[63-8*j -: 8] = 8'(8 * w + j);
    return word;
  endfunction

  always @(posedge clk) if (if_l1.o_res_en) if_l1.i_res <= mem_word(int'(if_l1.o_res_addr));
  always @(posedge clk) if (if_l3.o_res_en) if_l3.i_res <= mem_word(int'(if_l3.o_res_addr));
  always @(posedge clk) if (if_ot.o_res_en) if_ot.i_res <= mem_word(int'(if_ot.o_res_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard / stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (valid_a[d] && ready_v[d]) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_spurious_byte: got 0x%0h expected no byte", d, byte_a[d]);
        end else begin
          check($sformatf("dut%0d_byte", d), 32'(byte_a[d]), 32'(exp_q[d].pop_front()));
        end
        xfer_cnt[d] <= xfer_cnt[d] + 1;
      end
      if (hold_pend[d] === 1'b1) begin
        check($sformatf("dut%0d_valid_held", d), 32'(valid_a[d]), 32'd1);
        check($sformatf("dut%0d_byte_held", d), 32'(byte_a[d]), 32'(held_b[d]));
      end
      hold_pend[d] <= valid_a[d] && !ready_v[d];
      held_b[d]    <= byte_a[d];
      if (done_a[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  task automatic drive_ready(input vec_t v, input int stalls);
    case (v.mode)
      RDY_ALWAYS: ready_v[v.dut] = 1'b1;
      RDY_RANDOM: ready_v[v.dut] = ($urandom_range(0, 99) < 30);
      default:    ready_v[v.dut] = (stalls >= 5);
    endcase
  endtask

  // One full unload. The cycle count is the number of rising edges after the
  // edge that accepts i_start, up to the edge that raises o_done.
  task automatic run_unload(input vec_t v);
    int d;
    int cyc;
    int stalls;
    int max_addr;
    int xbase;
    int dbase;
    bit seen_done;
    d        = v.dut;
    xbase    = xfer_cnt[d];
    dbase    = done_cnt[d];
    stalls   = 0;
    max_addr = 0;
    seen_done = 1'b0;
    for (int i = 0; i < v.exp_bytes; i++) exp_q[d].push_back(8'(i));
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    cyc = 0;
    drive_ready(v, stalls);
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      if (res_en_a[d] && addr_a[d] > max_addr) max_addr = addr_a[d];
      if (done_a[d]) begin
        seen_done = 1'b1;
      end else begin
        if (valid_a[d] && !ready_v[d]) stalls++;
        @(posedge clk);
        cyc++;
        #1;
        drive_ready(v, stalls);
        if (v.poke) start_v[d] = (cyc == 20);
      end
    end
    check({v.name, "_done_seen"}, 32'(seen_done), 32'd1);
    if (v.exp_cycles > 0) check({v.name, "_latency"}, 32'(cyc), 32'(v.exp_cycles));
    if (v.poke) begin
      start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
    end
    repeat (6) @(negedge clk);
    ready_v[d] = 1'b0;
    #1;
    check({v.name, "_byte_count"}, 32'(xfer_cnt[d] - xbase), 32'(v.exp_bytes));
    check({v.name, "_bytes_left"}, 32'(exp_q[d].size()), 32'd0);
    check({v.name, "_done_pulses"}, 32'(done_cnt[d] - dbase), 32'd1);
    check({v.name, "_max_addr"}, 32'(max_addr), 32'(v.exp_max_addr));
    check({v.name, "_busy_after"}, 32'(busy_a[d]), 32'd0);
    check({v.name, "_res_en_after"}, 32'(res_en_a[d]), 32'd0);
  endtask

  task automatic check_outputs_zero(input int d, input string tag);
    check($sformatf("%s_dut%0d_res_en", tag, d), 32'(res_en_a[d]), 32'd0);
    check($sformatf("%s_dut%0d_addr", tag, d), 32'(addr_a[d]), 32'd0);
    check($sformatf("%s_dut%0d_byte", tag, d), 32'(byte_a[d]), 32'd0);
    check($sformatf("%s_dut%0d_valid", tag, d), 32'(valid_a[d]), 32'd0);
    check($sformatf("%s_dut%0d_busy", tag, d), 32'(busy_a[d]), 32'd0);
    check($sformatf("%s_dut%0d_done", tag, d), 32'(done_a[d]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xb;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start_v = '0;
    ready_v = '0;
    for (int d = 0; d < 3; d++) begin
      xfer_cnt[d]  = 0;
      done_cnt[d]  = 0;
    end

    // L1: 104 bytes in 13 words -> 13*10 edges; L3: 20 words, last holds 7
    // bytes -> 19*10 + 2 + 7 edges; other: 1 word, 5 stalls -> 2 + 5 + 8.
    vecs[0] = '{0, RDY_ALWAYS, 1'b0, 104, 130, 12, "l1_stream"};
    vecs[1] = '{1, RDY_ALWAYS, 1'b0, 159, 199, 19, "l3_stream"};
    vecs[2] = '{0, RDY_RANDOM, 1'b0, 104, -1, 12, "l1_random_ready"};
    vecs[3] = '{2, RDY_HOLD5, 1'b0, 8, 15, 0, "other_hold5"};
    vecs[4] = '{0, RDY_ALWAYS, 1'b1, 104, 130, 12, "l1_start_ignored"};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_outputs_zero(d, "reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_unload(vecs[i]);

    // Reset in the middle of an L1 unload, then a clean restart from byte 0.
    xb = xfer_cnt[0];
    for (int i = 0; i < 104; i++) exp_q[0].push_back(8'(i));
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (xfer_cnt[0] - xb >= 51) break;
    end
    check("midreset_reached_byte50", 32'(xfer_cnt[0] - xb >= 51), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero(0, "midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q[0].delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(valid_a[0]), 32'd0);
      check("post_reset_busy", 32'(busy_a[0]), 32'd0);
    end
    ready_v[0] = 1'b0;
    run_unload(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
